// File: rtl/hd_bundle_accumulator_pkg.sv
// Shared types and helpers for the hypervector bundling accumulator.
package pkg_hd_bundle;

  localparam int unsigned CounterWidth = 8;

  typedef enum logic [1:0] {StIdle, StAccum, StOutput} state_e;

  typedef logic [CounterWidth-1:0] counter_t;

  function automatic int unsigned max_samples(input int unsigned cw);
    return (32'd1 << cw) - 32'd1;
  endfunction

  // Strict majority: 2*ones > n; an exact tie takes tiebit.
  function automatic logic majority(input logic [31:0] ones, input logic [31:0] n,
                                    input logic tiebit);
    logic [32:0] twice;
    twice = {ones, 1'b0};
    if (twice > {1'b0, n}) return 1'b1;
    if (twice == {1'b0, n}) return tiebit;
    return 1'b0;
  endfunction

endpackage

// File: rtl/hd_bit_counter.sv
// Per-bit saturating ones-counter with majority decision on the post-update count.
module hd_bit_counter
  import pkg_hd_bundle::*;
#(
  parameter int unsigned COUNTER_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     inc_i,
  input  logic                     restart_i,
  input  logic                     bit_i,
  input  logic [COUNTER_WIDTH-1:0] n_next_i,
  input  logic                     tie_i,
  output logic                     maj_o
);

  localparam logic [COUNTER_WIDTH-1:0] OnesMax = '1;

  logic [COUNTER_WIDTH-1:0] ones_q, ones_d, ones_upd;

  always_comb begin
    // First vector of a bundle replaces whatever the previous bundle left behind.
    if (restart_i) begin
      ones_upd = COUNTER_WIDTH'(bit_i);
    end else if (ones_q == OnesMax) begin
      ones_upd = ones_q;
    end else begin
      ones_upd = ones_q + COUNTER_WIDTH'(bit_i);
    end

    ones_d = ones_q;
    if (clear_i) begin
      ones_d = '0;
    end else if (inc_i) begin
      ones_d = ones_upd;
    end

    maj_o = majority(32'(ones_upd), 32'(n_next_i), tie_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/hd_bundle_accumulator.sv
// Bundles a stream of hypervectors into one by per-bit majority vote.
// Optional HD_BUNDLE_TIEBREAK_EN: ties take the bundle's first vector bit instead of 0.
module hd_bundle_accumulator
  import pkg_hd_bundle::*;
#(
  parameter int unsigned VECTOR_WIDTH  = 256,
  parameter int unsigned COUNTER_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [VECTOR_WIDTH-1:0]  hv_i,
  input  logic                     last_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [VECTOR_WIDTH-1:0]  hv_o,
  output logic [COUNTER_WIDTH-1:0] count_o
);

  localparam logic [COUNTER_WIDTH-1:0] MaxSamples = COUNTER_WIDTH'(max_samples(COUNTER_WIDTH));
  localparam logic [COUNTER_WIDTH-1:0] One        = COUNTER_WIDTH'(1);

  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] n_q, n_d, n_upd;
  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic [VECTOR_WIDTH-1:0]  hv_q, hv_d;
  logic [VECTOR_WIDTH-1:0]  maj, tie;
  logic                     accept, restart, close;

  assign ready_o = !clear_i && (state_q != StOutput);
  assign valid_o = (state_q == StOutput);
  assign hv_o    = hv_q;
  assign count_o = count_q;

  assign accept  = valid_i && ready_o;
  assign restart = (state_q == StIdle);
  assign n_upd   = restart ? One : n_q + One;
  assign close   = accept && (last_i || (n_upd == MaxSamples));

  for (genvar g = 0; g < VECTOR_WIDTH; g++) begin : g_bit
    hd_bit_counter #(
      .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_bit_counter (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (clear_i),
      .inc_i    (accept),
      .restart_i(restart),
      .bit_i    (hv_i[g]),
      .n_next_i (n_upd),
      .tie_i    (tie[g]),
      .maj_o    (maj[g])
    );
  end

`ifdef HD_BUNDLE_TIEBREAK_EN
  logic [VECTOR_WIDTH-1:0] first_q, first_d;

  // A single-vector bundle cannot tie, so using hv_i directly on restart is safe.
  assign tie     = restart ? hv_i : first_q;
  assign first_d = (accept && restart) ? hv_i : first_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      first_q <= '0;
    end else begin
      first_q <= first_d;
    end
  end
`else
  assign tie = '0;
`endif

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    hv_d    = hv_q;
    count_d = count_q;
    if (clear_i) begin
      state_d = StIdle;
      n_d     = '0;
    end else begin
      unique case (state_q)
        StIdle, StAccum: begin
          if (accept) begin
            n_d     = n_upd;
            state_d = StAccum;
            if (close) begin
              state_d = StOutput;
              hv_d    = maj;
              count_d = n_upd;
            end
          end
        end
        StOutput: begin
          if (ready_i) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      n_q     <= '0;
      hv_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      hv_q    <= hv_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_hd_bundle_accumulator.sv
// Scoreboard bench for hd_bundle_accumulator; honours HD_BUNDLE_TIEBREAK_EN like the design.
module tb_hd_bundle_accumulator;

  localparam int VW = 256;
  localparam int CW = 8;
  localparam int MaxN = 255;

  logic          clk = 1'b0;
  logic          rst, clear, valid_i, ready_o, last, valid_o, ready_i;
  logic [VW-1:0] hv_i, hv_o;
  logic [CW-1:0] count_o;

  typedef struct packed {
    logic [VW-1:0] hv;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            n_push = 0;
  int            n_drop = 0;
  int            n_out = 0;
  int            ones[VW];
  int            m_n = 0;
  logic [VW-1:0] m_first;

  hd_bundle_accumulator #(
    .VECTOR_WIDTH (VW),
    .COUNTER_WIDTH(CW)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .clear_i(clear),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .hv_i   (hv_i),
    .last_i (last),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .hv_o   (hv_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_accept(input logic [VW-1:0] hv, input logic lst, output bit closed);
    exp_t e;
    closed = 1'b0;
    if (m_n == 0) begin
      for (int b = 0; b < VW; b++) ones[b] = 0;
      m_first = hv;
    end
    for (int b = 0; b < VW; b++) ones[b] += int'(hv[b]);
    m_n++;
    if (lst || m_n == MaxN) begin
      for (int b = 0; b < VW; b++) begin
        if (2 * ones[b] > m_n) e.hv[b] = 1'b1;
        else if (2 * ones[b] == m_n) begin
`ifdef HD_BUNDLE_TIEBREAK_EN
          e.hv[b] = m_first[b];
`else
          e.hv[b] = 1'b0;
`endif
        end else e.hv[b] = 1'b0;
      end
      e.cnt = CW'(m_n);
      sb.push_back(e);
      n_push++;
      m_n = 0;
      closed = 1'b1;
    end
  endtask

  task automatic send(input logic [VW-1:0] hv, input logic lst);
    bit ok = 1'b0;
    bit closed;
    @(negedge clk);
    valid_i = 1'b1;
    hv_i    = hv;
    last    = lst;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (ready_o) ok = 1'b1;
    end
    if (!ok) begin
      check_eq("send_timeout", VW'(0), VW'(1));
      valid_i = 1'b0;
      return;
    end
    model_accept(hv, lst, closed);
    if (closed) begin
      @(negedge clk);
      #1;
      check_eq("valid_latency", VW'(valid_o), VW'(1));
    end
  endtask

  task automatic idle();
    @(negedge clk);
    valid_i = 1'b0;
    last    = 1'b0;
  endtask

  function automatic logic [VW-1:0] rnd_hv();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_valid"}, VW'(valid_o), VW'(0));
    check_eq({tag, "_ready"}, VW'(ready_o), VW'(1));
    check_eq({tag, "_count"}, VW'(count_o), VW'(0));
    check_eq({tag, "_hv"}, hv_o, VW'(0));
  endtask

  // Output monitor: a transfer happens at the next rising edge when valid_o & ready_i.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (valid_o && ready_i && !rst) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_out", VW'(1), VW'(0));
        end else begin
          e = sb.pop_front();
          check_eq("hv_o", hv_o, e.hv);
          check_eq("count_o", VW'(count_o), VW'(e.cnt));
          n_out++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t          e;
    logic [VW-1:0] all_ones;
    all_ones = '1;
    rst     = 1'b1;
    clear   = 1'b0;
    valid_i = 1'b0;
    last    = 1'b0;
    hv_i    = '0;
    ready_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    // Majority of three: every bit set in exactly two vectors.
    send({32{8'hF0}}, 1'b0);
    send({32{8'hFF}}, 1'b0);
    send({32{8'h0F}}, 1'b1);
    idle();
    repeat (2) @(negedge clk);

    // Two complementary vectors tie on every bit.
    send({32{8'hAA}}, 1'b0);
    send({32{8'h55}}, 1'b1);
    idle();

    // Odd-sized random bundle.
    for (int i = 0; i < 5; i++) send(rnd_hv(), i == 4);
    idle();
    repeat (2) @(negedge clk);

    // Downstream stall: result held, no input consumed.
    ready_i = 1'b0;
    send({32{8'h3C}}, 1'b1);
    e = sb[0];
    @(negedge clk);
    valid_i = 1'b1;
    hv_i    = rnd_hv();
    last    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check_eq("stall_ready", VW'(ready_o), VW'(0));
      check_eq("stall_valid", VW'(valid_o), VW'(1));
      check_eq("stall_hv", hv_o, e.hv);
      check_eq("stall_count", VW'(count_o), VW'(e.cnt));
    end
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (2) @(negedge clk);

    // Implicit close at the sample-counter limit; the next vector must wait.
    ready_i = 1'b0;
    for (int i = 0; i < MaxN; i++) send(all_ones, 1'b0);
    @(negedge clk);
    valid_i = 1'b1;
    hv_i    = all_ones;
    last    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_eq("sat_stall_ready", VW'(ready_o), VW'(0));
    end
    @(negedge clk);
    ready_i = 1'b1;
    send(all_ones, 1'b1);
    idle();
    repeat (2) @(negedge clk);

    // Abort a partial bundle, then a single-vector bundle.
    send(rnd_hv(), 1'b0);
    send(rnd_hv(), 1'b0);
    @(negedge clk);
    clear   = 1'b1;
    valid_i = 1'b1;
    hv_i    = rnd_hv();
    last    = 1'b1;
    #1;
    check_eq("clear_ready", VW'(ready_o), VW'(0));
    @(negedge clk);
    clear   = 1'b0;
    valid_i = 1'b0;
    m_n     = 0;
    #1;
    check_eq("clear_valid", VW'(valid_o), VW'(0));
    send({32{8'h12}}, 1'b1);
    idle();
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-accumulation.
    send(rnd_hv(), 1'b0);
    send(rnd_hv(), 1'b0);
    idle();
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("rst_accum");
    m_n = 0;
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset while holding a result.
    ready_i = 1'b0;
    send(rnd_hv(), 1'b0);
    send(rnd_hv(), 1'b1);
    idle();
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("rst_output");
    void'(sb.pop_back());
    n_drop++;
    @(negedge clk);
    rst     = 1'b0;
    ready_i = 1'b1;

    // Recovery after reset.
    for (int i = 0; i < 3; i++) send(rnd_hv(), i == 2);
    idle();
    repeat (5) @(negedge clk);

    check_eq("sb_empty", VW'(sb.size()), VW'(0));
    check_eq("out_count", VW'(n_out), VW'(n_push - n_drop));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
